// File: rtl/char_transmit_control_pkg.sv
// Serial framing constants shared by the transmit and receive character paths.
// Both ends import this so their bit/sample numbering stays identical.
package char_transmit_control_pkg;

    localparam int SAMPLES_PER_BIT = 16;
    localparam logic [3:0] BSC_LAST = 4'(SAMPLES_PER_BIT - 1);

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Start + data + stop, as a count of bit slots in one character frame.
    function automatic int frame_bits(input int data_bits);
        return data_bits + 2;
    endfunction

    localparam int FRAME_BITS = frame_bits(8);

endpackage

// File: rtl/char_transmit_control_bit_sample_counter.sv
// Bit identifier / bit sample counter pair (BIC/BSC) with enable, clear and wrap.
// Shared with the receive side so both ends number bits and samples the same way.
module bit_sample_counter
    import char_transmit_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] bsc,
    output logic [3:0] bic
);

    logic [3:0] bsc_r;
    logic [3:0] bic_r;

    // Sample count advances every enabled clock; bit count advances when it wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsc_r <= 4'd0;
            bic_r <= 4'd0;
        end else if (clear) begin
            bsc_r <= 4'd0;
            bic_r <= 4'd0;
        end else if (enable) begin
            if (bsc_r == BSC_LAST) begin
                bsc_r <= 4'd0;
                bic_r <= bic_r + 4'd1;
            end else begin
                bsc_r <= bsc_r + 4'd1;
            end
        end
    end

    assign bsc = bsc_r;
    assign bic = bic_r;

endmodule

// File: rtl/char_transmit_control.sv
// Serial character transmitter: start bit, DATA_BITS data bits LSB-first, stop bit,
// each bit held for 16 enabled clocks of the 16x sample clock.
module char_transmit_control
    import char_transmit_control_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] txData,
    output logic       serialOut,
    output logic       txBusy,
    output logic       charSent,
    output logic [3:0] BIC,
    output logic [3:0] BSC
);

    localparam logic [3:0] LAST_DATA_BIC = 4'(DATA_BITS);
    localparam logic [3:0] STOP_BIC      = 4'(frame_bits(DATA_BITS) - 1);

    logic [0:0]           state_r;
    logic [0:0]           state_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic                 serial_r;
    logic                 serial_next_s;
    logic                 busy_r;
    logic                 busy_next_s;
    logic                 sent_r;
    logic [3:0]           bic_s;
    logic [3:0]           bsc_s;
    logic                 step_s;
    logic                 wrap_s;
    logic                 frame_end_s;
    logic                 cnt_clear_s;

    assign step_s      = (state_r == SEND) && enable;
    assign wrap_s      = step_s && (bsc_s == BSC_LAST);
    assign frame_end_s = wrap_s && (bic_s == STOP_BIC);
    assign cnt_clear_s = (state_r == IDLE) || frame_end_s;

    bit_sample_counter u_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (cnt_clear_s),
        .enable (step_s),
        .bsc    (bsc_s),
        .bic    (bic_s)
    );

    // Next state, shift register and line level; the line only changes on bit boundaries.
    // At each boundary the line takes the current LSB and the register shifts, so the
    // register always holds the next bit to send.
    always_comb begin
        state_next_s  = state_r;
        shift_next_s  = shift_r;
        serial_next_s = serial_r;
        busy_next_s   = busy_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_next_s  = SEND;
                    shift_next_s  = txData[DATA_BITS-1:0];
                    serial_next_s = START_BIT;
                    busy_next_s   = 1'b1;
                end else begin
                    serial_next_s = STOP_BIT;
                    busy_next_s   = 1'b0;
                end
            end
            SEND: begin
                if (frame_end_s) begin
                    state_next_s  = IDLE;
                    serial_next_s = STOP_BIT;
                    busy_next_s   = 1'b0;
                end else if (wrap_s) begin
                    if (bic_s < LAST_DATA_BIC) begin
                        serial_next_s = shift_r[0];
                        shift_next_s  = shift_r >> 1;
                    end else begin
                        serial_next_s = STOP_BIT;
                    end
                end else begin
                    serial_next_s = serial_r;
                end
            end
            default: begin
                state_next_s  = IDLE;
                serial_next_s = STOP_BIT;
                busy_next_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line back to mark immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            serial_r <= STOP_BIT;
            busy_r   <= 1'b0;
            sent_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            shift_r  <= shift_next_s;
            serial_r <= serial_next_s;
            busy_r   <= busy_next_s;
            sent_r   <= frame_end_s;
        end
    end

    assign serialOut = serial_r;
    assign txBusy    = busy_r;
    assign charSent  = sent_r;
    assign BIC       = bic_s;
    assign BSC       = bsc_s;

endmodule

// File: tb/tb_char_transmit_control.sv
// Directed bench for char_transmit_control: frame shape, busy loads, back-to-back,
// enable stalls, mid-frame reset and a counter-driven receive decode.
module tb_char_transmit_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       serialOut;
    logic       txBusy;
    logic       charSent;
    logic [3:0] BIC;
    logic [3:0] BSC;

    int n_checks = 0;
    int n_errors = 0;
    int sent_cnt = 0;

    char_transmit_control #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .txData    (txData),
        .serialOut (serialOut),
        .txBusy    (txBusy),
        .charSent  (charSent),
        .BIC       (BIC),
        .BSC       (BSC)
    );

    always #5 clk = ~clk;

    // Count charSent pulses mid-period, away from the active edge.
    always @(negedge clk) begin
        if (charSent) sent_cnt <= sent_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] d);
        txData = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // Walks one frame from the period after the accepting edge up to the charSent
    // period (no tick past it). Optional enable stall and a load attempt mid-frame.
    task automatic frame_body(input string tag, input logic [7:0] d, input int stall_at,
                              input int stall_len, input int load_at, input logic [7:0] load_d);
        logic [9:0] fr;
        logic [9:0] rx;
        int k;
        int p;
        int stalled;
        fr = {1'b1, d, 1'b0};
        rx = 10'h000;
        k = 0;
        p = 0;
        stalled = 0;
        while (k < 160 && p < 400) begin
            check_eq({tag, " line"}, 32'(serialOut), 32'(fr[k/16]));
            check_eq({tag, " bic"}, 32'(BIC), 32'(k / 16));
            check_eq({tag, " bsc"}, 32'(BSC), 32'(k % 16));
            check_eq({tag, " busy/sent"}, {30'd0, txBusy, charSent}, 32'd2);
            if (BSC == 4'd8 && BIC <= 4'd9) rx[BIC] = serialOut;
            enable = !(k == stall_at && stalled < stall_len);
            if (!enable) stalled++;
            load = (k == load_at);
            if (load) txData = load_d;
            tick();
            p++;
            if (enable) k++;
        end
        load   = 1'b0;
        enable = 1'b1;
        check_eq({tag, " length"}, 32'(p), 32'(160 + stall_len));
        check_eq({tag, " end sent/busy/line"}, {29'd0, charSent, txBusy, serialOut}, 32'b101);
        check_eq({tag, " end bic"}, 32'(BIC), 32'd0);
        check_eq({tag, " end bsc"}, 32'(BSC), 32'd0);
        check_eq({tag, " rx frame"}, 32'(rx), 32'(fr));
    endtask

    initial begin
        int bad;
        int sent_snap;

        // Reset state.
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check_eq("rst line", 32'(serialOut), 32'd1);
        check_eq("rst busy", 32'(txBusy), 32'd0);
        check_eq("rst sent", 32'(charSent), 32'd0);
        check_eq("rst bic", 32'(BIC), 32'd0);
        check_eq("rst bsc", 32'(BSC), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check_eq("idle bsc", 32'(BSC), 32'd0);
        check_eq("idle line", 32'(serialOut), 32'd1);

        // 0x41: 0,1,0,0,0,0,0,1,0,1 on the line.
        start_frame(8'h41);
        frame_body("x41", 8'h41, -1, 0, -1, 8'h00);
        tick();
        check_eq("x41 pulses", 32'(sent_cnt), 32'd1);
        check_eq("x41 pulse width", 32'(charSent), 32'd0);

        // 0xA3 with an ignored load of 0x55 mid-frame; nothing follows.
        start_frame(8'hA3);
        frame_body("xA3", 8'hA3, -1, 0, 20, 8'h55);
        bad = 0;
        repeat (40) begin
            tick();
            if (txBusy !== 1'b0 || serialOut !== 1'b1) bad++;
        end
        check_eq("xA3 no second frame", 32'(bad), 32'd0);
        check_eq("xA3 pulses", 32'(sent_cnt), 32'd2);

        // Back-to-back 0x00 then 0xFF, load held in the charSent cycle.
        start_frame(8'h00);
        frame_body("x00", 8'h00, -1, 0, -1, 8'h00);
        txData = 8'hFF;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check_eq("b2b start bit", 32'(serialOut), 32'd0);
        check_eq("b2b busy", 32'(txBusy), 32'd1);
        frame_body("xFF", 8'hFF, -1, 0, -1, 8'h00);
        tick();
        check_eq("b2b pulses", 32'(sent_cnt), 32'd4);

        // Enable dropped for 5 cycles at BIC=3, BSC=7 (enabled cycle 55).
        start_frame(8'h96);
        frame_body("stall", 8'h96, 55, 5, -1, 8'h00);
        tick();
        check_eq("stall pulses", 32'(sent_cnt), 32'd5);

        // Reset during BIC=4 of 0xC3 (data bit 3 = 0 on the line).
        start_frame(8'hC3);
        repeat (67) tick();
        check_eq("abort pre bic", 32'(BIC), 32'd4);
        check_eq("abort pre line", 32'(serialOut), 32'd0);
        sent_snap = sent_cnt;
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort line", 32'(serialOut), 32'd1);
        check_eq("abort busy", 32'(txBusy), 32'd0);
        check_eq("abort bic", 32'(BIC), 32'd0);
        check_eq("abort bsc", 32'(BSC), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (200) tick();
        check_eq("abort no pulse", 32'(sent_cnt), 32'(sent_snap));

        // Fresh frame after reset, decoded from BIC/BSC like a paired receiver.
        start_frame(8'h5A);
        frame_body("loop5A", 8'h5A, -1, 0, -1, 8'h00);
        tick();
        check_eq("loop pulses", 32'(sent_cnt), 32'(sent_snap + 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/char_transmit_control.md
# char_transmit_control

Serial character transmitter for the processor's serial port, the send-side counterpart of the receive character/bit counter. Accepts an 8-bit character on a load strobe and shifts it out LSB-first as a 10-bit frame: one start bit (0), 8 data bits, one stop bit (1). Each bit is held for 16 enabled cycles of the 16x sample clock. Bit and sample counters are exposed under the same names and meaning as on the receive side, so the two ends can be paired in loopback.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5–8; frame length = DATA_BITS + 2
- SAMPLES_PER_BIT, 16, fixed; enabled clocks per bit (BSC is 4 bits wide)

- clk  input  1  16x sample clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; one clock; async assert, sync release by the system reset logic
- enable  input  1  count enable; when 0, all counters, state and serialOut hold
- load  input  1  request to send txData; sampled on the rising clk edge
- txData  input  8  character to send; captured on an accepted load
- serialOut  output  1  serial line; idle/mark = 1
- txBusy  output  1  1 from accepted load until the end of the stop bit
- charSent  output  1  one-cycle pulse after the stop bit completes
- BIC  output  4  bit identifier count: 0 = start, 1..DATA_BITS = data, DATA_BITS+1 = stop
- BSC  output  4  bit sample count, 0..15 within the current bit

## Operation
- States: IDLE, SEND.
- Reset values: state IDLE, serialOut=1, txBusy=0, charSent=0, BIC=0, BSC=0, shift register 0.
- IDLE: serialOut=1 and BIC=BSC=0. On a clock edge with load=1, txData is captured into the shift register, state goes to SEND and BIC=BSC=0. Load is accepted regardless of enable.
- SEND, on an edge with enable=1:
  - BSC increments.
  - When BSC=15, BSC wraps to 0 and BIC increments. On a data-to-data or start-to-data transition, the shift register shifts right.
- serialOut is registered:
  - 0 while BIC=0
  - shift register bit 0 while 1 ≤ BIC ≤ DATA_BITS
  - 1 while BIC = DATA_BITS+1
- End of frame: an edge in SEND with enable=1, BIC=DATA_BITS+1 and BSC=15 sets state to IDLE, BIC=BSC=0, txBusy=0 and charSent=1 for exactly one cycle.
- Load while busy: load=1 in SEND is ignored. txData is not captured and the frame in progress is unaffected. There is no queueing.
- Back-to-back: load=1 in the charSent cycle is accepted. The next start bit begins with no idle gap.
- Reset mid-frame: the frame is aborted. serialOut returns to 1 immediately (asynchronously). No charSent is produced.

## Timing
- Load accepted at edge E0. From E0, serialOut=0 and txBusy=1.
- Each bit lasts exactly 16 enabled cycles.
- With enable held high, the frame lasts 160 cycles (DATA_BITS=8). charSent is high during cycle 160 after E0, and txBusy is 0 in that same cycle.
- Each cycle with enable=0 during SEND extends the frame by exactly one cycle. The output bit does not change.
- charSent never overlaps txBusy=1 except when a load is accepted in the charSent cycle; txBusy rises on the following edge.

## Structure
- Shared package/include (serial_defs): FRAME_BITS, SAMPLES_PER_BIT, START_BIT=0, STOP_BIT=1, state encoding IDLE/SEND. The receive side uses the same constants.
- Sub-module bit_sample_counter: BSC/BIC pair with enable, clear and wrap, reusable by the receive side.
- The top level holds the FSM, the shift register and the output register.

## Test plan
- Reset then send 0x41 with enable=1: serialOut holds, 16 cycles each, the sequence 0,1,0,0,0,0,0,1,0,1. charSent pulses once at cycle 160 and txBusy falls at the same point.
- Load 0x55 while busy sending 0xA3: the line carries only 0xA3's bits (1,1,0,0,0,1,0,1 LSB-first). No second frame follows.
- Back-to-back 0x00 then 0xFF with load asserted in the charSent cycle: the stop-bit 1 is immediately followed by the start-bit 0. Total 320 cycles and two charSent pulses.
- Drop enable for 5 cycles during BIC=3, BSC=7: BIC, BSC and serialOut are frozen. The frame completes at cycle 165.
- Assert reset at BIC=4 mid-frame: serialOut=1, txBusy=0, BIC=BSC=0 immediately. No charSent. A fresh load after release sends a complete frame.
- Loopback serialOut into the receive counter for 0x5A: the receiver's charReceived fires with data 0x5A, and BIC/BSC track within one frame.
